// File: rtl/shift_pkg.sv
// Shared types and defaults for the shift-unit initiator (shift_ctrl) and its latency counter.
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 6;
    localparam int DEF_EXTRA = 2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/shift_lat_cnt.sv
// Loadable down-counter that times out a shifter's latency; term is high while the count is 1,
// i.e. during the last cycle of the wait.
module shift_lat_cnt #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          term
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state is only ever written with <= in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term = (count_q == CW'(1));

endmodule

// File: rtl/shift_ctrl.sv
// Initiator for the iterative shiftleft/shiftright units: accepts one request, launches the
// selected shifter, waits out its latency and holds the result until the consumer takes it.
module shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW,
    parameter int EXTRA = DEF_EXTRA
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_dir,
    input  logic [WIDTH-1:0] req_a,
    input  logic [SHW-1:0]   req_b,
    output logic [WIDTH-1:0] sh_a,
    output logic [SHW-1:0]   sh_b,
    output logic             sh_start_l,
    output logic             sh_start_r,
    input  logic [WIDTH-1:0] sh_c_left,
    input  logic [WIDTH-1:0] sh_c_right,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_dir,
    output logic             busy
);

    localparam int                CW        = SHW + 2;
    localparam logic [SHW:0]      WIDTH_LIM = (SHW + 1)'(WIDTH);
    localparam logic [CW-1:0]     EXTRA_V   = CW'(EXTRA);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [SHW-1:0]   b_q, b_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             in_flight;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_term;
    logic [CW-1:0]    cnt_load_val;

    assign cnt_load     = (state_q == ST_LAUNCH);
    assign cnt_dec      = (state_q == ST_WAIT);
    assign cnt_load_val = CW'(b_q) + EXTRA_V;

    shift_lat_cnt #(
        .CW (CW)
    ) u_lat_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .term     (cnt_term)
    );

    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        dir_d      = dir_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d   = req_a;
                    b_d   = req_b;
                    dir_d = req_dir;
                    // Zero and out-of-range distances never touch the shifters.
                    if (req_b == '0) begin
                        rsp_data_d = req_a;
                        state_d    = ST_DONE;
                    end else if ({1'b0, req_b} >= WIDTH_LIM) begin
                        rsp_data_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        state_d    = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_term) begin
                    rsp_data_d = (dir_q == DIR_RIGHT) ? sh_c_right : sh_c_left;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            dir_q      <= DIR_LEFT;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            dir_q      <= dir_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Outputs decode directly from the async-reset state, so they drop the moment reset rises.
    assign in_flight  = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign busy       = (state_q != ST_IDLE);
    assign sh_a       = in_flight ? a_q : '0;
    assign sh_b       = in_flight ? b_q : '0;
    assign sh_start_l = (state_q == ST_LAUNCH) && (dir_q == DIR_LEFT);
    assign sh_start_r = (state_q == ST_LAUNCH) && (dir_q == DIR_RIGHT);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_data   = rsp_data_q;
    assign rsp_dir    = dir_q;

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Initiator-side controller for the ALU's iterative shift units (shiftleft / shiftright). It accepts one shift request at a time over a valid/ready handshake and drives the shared operand bus and a one-cycle start pulse into the selected shifter. It waits out the shifter's operand-dependent latency, then captures the result into a held response register presented with valid/ready. Zero-distance and out-of-range shifts bypass the shifters entirely.

## Interface
- WIDTH, 32, data width of operands and result
- SHW, 6, width of shift-amount field
- EXTRA, 2, settle cycles added to B while waiting on a shifter
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_dir  in  1  0 = left, 1 = right
- req_a  in  WIDTH  operand A
- req_b  in  SHW  shift distance B
- sh_a  out  WIDTH  operand to both shifters
- sh_b  out  SHW  distance to both shifters
- sh_start_l  out  1  start pulse to shiftleft
- sh_start_r  out  1  start pulse to shiftright
- sh_c_left  in  WIDTH  shiftleft result
- sh_c_right  in  WIDTH  shiftright result
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_data  out  WIDTH  shift result
- rsp_dir  out  1  direction of the completed request
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: req_ready=1. On req_valid: latch a, b, dir.
  - B==0: rsp_data=A, go DONE.
  - B>=WIDTH: rsp_data=0, go DONE.
  - Otherwise: go LAUNCH.
- LAUNCH: exactly one cycle. Raise sh_start_l or sh_start_r per dir; the other stays 0. Load counter with B+EXTRA. Go WAIT.
- WAIT: decrement counter each edge. At the edge where counter==1, capture sh_c_left or sh_c_right into rsp_data and go DONE.
- DONE: rsp_valid=1; rsp_data and rsp_dir stable. On rsp_ready go IDLE. rsp_ready outside DONE is ignored.
- sh_a/sh_b hold latched operands from LAUNCH through the end of WAIT. They are 0 in IDLE.
- Reset values: state=IDLE, req_ready=1 after release (0 while reset asserted), all other outputs 0, counter 0.
- Reset mid-operation: abandon immediately, no response produced, start pulses drop asynchronously.

## Timing
- Accept edge = edge where req_valid && req_ready.
- Launched path: LAUNCH for 1 cycle, WAIT for B+EXTRA cycles. rsp_valid rises B+EXTRA+1 edges after the accept edge.
- Bypass path: rsp_valid rises on the accept edge (1-cycle latency).
- Start pulse is exactly one cycle wide, never re-asserted within a request.
- Throughput: no new request is accepted until the response is consumed. The minimum gap is 1 cycle of IDLE after a DONE handshake.
- Counter width is SHW+2 bits; B+EXTRA never wraps.

## Structure
- Package shift_pkg holds:
  - the state enum (IDLE/LAUNCH/WAIT/DONE)
  - DIR_LEFT=0 and DIR_RIGHT=1
  - default WIDTH, SHW, EXTRA constants
- One sub-module, shift_lat_cnt: a loadable down-counter with a terminal flag that pulses when the count is 1.
- Shifters are instantiated outside this block and wired by the parent.

## Test plan
- A=3072, B=3, dir=left, shiftleft model → rsp_data=24576, rsp_dir=0. rsp_valid rises 6 edges after accept. sh_start_l high exactly 1 cycle; sh_start_r stays 0.
- A=3072, B=3, dir=right → rsp_data=384, rsp_dir=1, same 6-edge latency.
- B=0, A=0xDEADBEEF → rsp_data=0xDEADBEEF one edge after accept; no start pulse. B=40 → rsp_data=0, no start pulse.
- Hold rsp_ready=0 for 10 cycles in DONE → rsp_valid and rsp_data stable; req_ready=0. A req_valid presented meanwhile is not accepted until 1 cycle after the rsp handshake.
- Assert reset 2 cycles into WAIT → all outputs 0 immediately. After release: IDLE, req_ready=1, no stray rsp_valid. A following request completes normally.
- Back-to-back: left B=1 on A=1, then right B=31 on A=0x80000000 → responses 2 then 1, in order.
